// File: rtl/register_pkg.sv
// Shared types and helpers for the register serializer slice.
package register_pkg;

    // Frame sequencer states: wait for a word, shift it out, one-cycle completion.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } ser_state_t;

    // Counter width for a count range of n values; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/register_serializer_if.sv
// Parallel-in handshake and serial-out bus of the register serializer.
//
// Handshake: the master holds data_i stable while valid_i is high; a word
// transfers on the rising edge where valid_i & ready_o are both 1. ready_o is
// decoded from registered state only, so it never depends on valid_i in the
// same cycle. The master may keep valid_i high while ready_o is low; the word
// is simply not taken until ready_o returns.
interface register_serializer_if #(
    parameter int N = 16
);
    import register_pkg::*;

    logic [N-1:0] data_i;
    logic         valid_i;
    logic         ready_o;
    logic         ser_o;
    logic         frame_o;
    logic         bit_stb_o;
    logic         done_o;
    ser_state_t   state;      // sequencer state, visible for checkers

    modport master (
        output data_i, valid_i,
        input  ready_o, ser_o, frame_o, bit_stb_o, done_o, state
    );

    modport slave (
        input  data_i, valid_i,
        output ready_o, ser_o, frame_o, bit_stb_o, done_o, state
    );

endinterface

// File: rtl/register_serializer_bit_timer.sv
// Bit-period timer: counts DIV enabled cycles and flags the last one of each bit.
module bit_timer
    import register_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic count_en,
    input  logic clear,
    output logic tick
);
    localparam int            CW   = cnt_width(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // tick marks the final cycle of a bit period, so the next bit starts after it.
    assign tick = count_en && (cnt == LAST);

    // Count 0..DIV-1 within each bit; restart on clear or at the end of a period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else if (count_en) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/register_serializer.sv
// Parallel-to-serial converter: MSB first, DIV clocks per bit, framed with
// frame/bit-strobe/done markers. All serial-side outputs are registered.
module register_serializer
    import register_pkg::*;
#(
    parameter int N   = 16,
    parameter int DIV = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    register_serializer_if.slave  bus
);
    localparam int            BW       = cnt_width(N);
    localparam logic [BW-1:0] LAST_BIT = BW'(N - 1);

    if (N < 2) begin : g_bad_n
        $error("register_serializer: N must be at least 2");
    end
    if (DIV < 1) begin : g_bad_div
        $error("register_serializer: DIV must be at least 1");
    end

    ser_state_t    state;
    logic [N-1:0]  shreg;
    logic [BW-1:0] bit_cnt;
    logic          ser;
    logic          frame;
    logic          stb;
    logic          done;
    logic          ready;
    logic          accept;
    logic          shifting;
    logic          tick;

    // Ready is a pure state decode; accept only qualifies it with valid.
    assign ready    = (state == IDLE);
    assign accept   = ready && bus.valid_i;
    assign shifting = (state == SHIFT);

    bit_timer #(
        .DIV (DIV)
    ) u_bit_timer (
        .clk      (clk_i),
        .rst      (rst_i),
        .count_en (shifting),
        .clear    (accept),
        .tick     (tick)
    );

    // Frame sequencer; outputs are set one edge ahead so they line up with state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            ser     <= 1'b1;
            frame   <= 1'b0;
            stb     <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state   <= SHIFT;
                        shreg   <= bus.data_i;
                        bit_cnt <= '0;
                        ser     <= bus.data_i[N-1];
                        frame   <= 1'b1;
                        stb     <= 1'b1;
                    end
                end
                SHIFT: begin
                    stb <= 1'b0;
                    if (tick) begin
                        if (bit_cnt == LAST_BIT) begin
                            state <= DONE;
                            ser   <= 1'b1;
                            frame <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            shreg   <= {shreg[N-2:0], 1'b0};
                            ser     <= shreg[N-2];
                            stb     <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    ser   <= 1'b1;
                    frame <= 1'b0;
                    stb   <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready_o   = ready;
    assign bus.ser_o     = ser;
    assign bus.frame_o   = frame;
    assign bus.bit_stb_o = stb;
    assign bus.done_o    = done;
    assign bus.state     = state;

endmodule

// File: tb/tb_register_serializer.sv
// Scoreboard bench for register_serializer: a 16-bit/DIV=4 instance and a
// 2-bit/DIV=1 instance share one clock and reset.
module tb_register_serializer;
    import register_pkg::*;

    typedef struct {
        bit          in_frame;
        int          cyc;
        logic [15:0] got;
        logic        cur;
        int          stb_cnt;
        int          acc_cnt;
        int          done_cnt;
    } mon_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q_a[$];
    logic [15:0] exp_q_b[$];

    mon_t mon_a = '{0, 0, 16'h0, 1'b0, 0, 0, 0};
    mon_t mon_b = '{0, 0, 16'h0, 1'b0, 0, 0, 0};

    // Clock and reset
    always #5 clk = ~clk;

    register_serializer_if #(.N(16)) a_if ();
    register_serializer_if #(.N(2))  b_if ();

    register_serializer #(.N(16), .DIV(4)) dut_a (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (a_if.slave)
    );

    register_serializer #(.N(2), .DIV(1)) dut_b (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (b_if.slave)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle protocol model: cycle 1 is the cycle after the accept edge.
    task automatic mon_step(input string tag, input int n, input int div,
                            input logic r, input logic ser, input logic frame,
                            input logic stb, input logic done, input logic ready,
                            input logic valid, inout mon_t m, output bit word_done);
        word_done = 1'b0;
        if (r) begin
            m.in_frame = 1'b0;
            m.cyc      = 0;
            chk({tag, " rst done"},  16'(done),  16'd0);
            chk({tag, " rst ready"}, 16'(ready), 16'd1);
            chk({tag, " rst frame"}, 16'(frame), 16'd0);
            chk({tag, " rst ser"},   16'(ser),   16'd1);
            return;
        end
        if (m.in_frame) begin
            m.cyc++;
            if (m.cyc <= n * div) begin
                chk({tag, " frame"}, 16'(frame), 16'd1);
                chk({tag, " stb"},   16'(stb),   16'(((m.cyc - 1) % div) == 0));
                chk({tag, " done"},  16'(done),  16'd0);
                chk({tag, " ready"}, 16'(ready), 16'd0);
                if (stb) begin
                    m.got = {m.got[14:0], ser};
                    m.cur = ser;
                    m.stb_cnt++;
                end else begin
                    chk({tag, " ser hold"}, 16'(ser), 16'(m.cur));
                end
            end else if (m.cyc == n * div + 1) begin
                chk({tag, " done pulse"},  16'(done),  16'd1);
                chk({tag, " done ser"},    16'(ser),   16'd1);
                chk({tag, " done frame"},  16'(frame), 16'd0);
                chk({tag, " done ready"},  16'(ready), 16'd0);
                chk({tag, " done stb"},    16'(stb),   16'd0);
                chk({tag, " stb count"},   16'(m.stb_cnt), 16'(n));
                m.done_cnt++;
                word_done = 1'b1;
            end else begin
                chk({tag, " ready back"}, 16'(ready), 16'd1);
                chk({tag, " post done"},  16'(done),  16'd0);
                chk({tag, " post frame"}, 16'(frame), 16'd0);
                chk({tag, " post ser"},   16'(ser),   16'd1);
                m.in_frame = 1'b0;
            end
        end else begin
            chk({tag, " idle ready"}, 16'(ready), 16'd1);
            chk({tag, " idle frame"}, 16'(frame), 16'd0);
            chk({tag, " idle done"},  16'(done),  16'd0);
            chk({tag, " idle stb"},   16'(stb),   16'd0);
            chk({tag, " idle ser"},   16'(ser),   16'd1);
        end
        if (valid && ready) begin
            m.in_frame = 1'b1;
            m.cyc      = 0;
            m.got      = 16'h0;
            m.stb_cnt  = 0;
            m.acc_cnt++;
        end
    endtask

    // Monitor for instance A: sample mid-cycle, compare finished words against the queue.
    always @(negedge clk) begin
        bit          wd;
        logic [15:0] e;
        mon_step("A", 16, 4, rst, a_if.ser_o, a_if.frame_o, a_if.bit_stb_o,
                 a_if.done_o, a_if.ready_o, a_if.valid_i, mon_a, wd);
        if (wd) begin
            if (exp_q_a.size() == 0) begin
                chk("A unexpected frame", 16'd1, 16'd0);
            end else begin
                e = exp_q_a.pop_front();
                chk("A word", mon_a.got, e);
            end
        end
    end

    // Monitor for instance B.
    always @(negedge clk) begin
        bit          wd;
        logic [15:0] e;
        mon_step("B", 2, 1, rst, b_if.ser_o, b_if.frame_o, b_if.bit_stb_o,
                 b_if.done_o, b_if.ready_o, b_if.valid_i, mon_b, wd);
        if (wd) begin
            if (exp_q_b.size() == 0) begin
                chk("B unexpected frame", 16'd1, 16'd0);
            end else begin
                e = exp_q_b.pop_front();
                chk("B word", mon_b.got, e);
            end
        end
    end

    // Driver tasks: called one time unit after a rising edge while the DUT is idle.
    task automatic send_a(input logic [15:0] w);
        a_if.data_i  = w;
        a_if.valid_i = 1'b1;
        exp_q_a.push_back(w);
        @(posedge clk); #1;
        a_if.valid_i = 1'b0;
        a_if.data_i  = ~w;
    endtask

    task automatic send_b(input logic [1:0] w);
        b_if.data_i  = w;
        b_if.valid_i = 1'b1;
        exp_q_b.push_back({14'h0, w});
        @(posedge clk); #1;
        b_if.valid_i = 1'b0;
        b_if.data_i  = ~w;
    endtask

    task automatic wait_a_idle();
        int t = 0;
        while ((mon_a.in_frame || exp_q_a.size() != 0) && t < 400) begin
            @(posedge clk); #1;
            t++;
        end
        chk("A idle timeout", 16'(t < 400), 16'd1);
    endtask

    task automatic wait_b_idle();
        int t = 0;
        while ((mon_b.in_frame || exp_q_b.size() != 0) && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        chk("B idle timeout", 16'(t < 100), 16'd1);
    endtask

    // Directed stimulus
    initial begin
        int a0;
        int t;
        int c;

        a_if.data_i  = 16'h0;
        a_if.valid_i = 1'b0;
        b_if.data_i  = 2'b00;
        b_if.valid_i = 1'b0;

        #1 rst = 1'b1;
        #2;
        chk("A reset ser",   16'(a_if.ser_o),     16'd1);
        chk("A reset frame", 16'(a_if.frame_o),   16'd0);
        chk("A reset stb",   16'(a_if.bit_stb_o), 16'd0);
        chk("A reset done",  16'(a_if.done_o),    16'd0);
        chk("A reset ready", 16'(a_if.ready_o),   16'd1);
        chk("A reset state", 16'(a_if.state),     16'(IDLE));
        chk("B reset ready", 16'(b_if.ready_o),   16'd1);
        chk("B reset ser",   16'(b_if.ser_o),     16'd1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Single word: 1010_0101_1100_0011, done at cycle 65, ready at 66.
        send_a(16'hA5C3);
        wait_a_idle();

        // Back-to-back words with valid held high: one DONE plus one IDLE cycle between frames.
        a0 = mon_a.acc_cnt;
        a_if.data_i  = 16'hFFFF;
        a_if.valid_i = 1'b1;
        exp_q_a.push_back(16'hFFFF);
        @(posedge clk); #1;
        a_if.data_i = 16'h0001;
        exp_q_a.push_back(16'h0001);
        t = 0;
        while (mon_a.acc_cnt != a0 + 2 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        a_if.valid_i = 1'b0;
        chk("A b2b spacing", 16'(t), 16'd66);
        wait_a_idle();

        // Valid held high with data changing every cycle: only 16'hC0DE, then the cycle-66 word.
        a0 = mon_a.acc_cnt;
        a_if.data_i  = 16'hC0DE;
        a_if.valid_i = 1'b1;
        exp_q_a.push_back(16'hC0DE);
        exp_q_a.push_back(16'h1042);
        @(posedge clk); #1;
        for (c = 1; c < 100; c++) begin
            a_if.data_i = 16'h1000 + 16'(c);
            @(posedge clk); #1;
            if (mon_a.acc_cnt == a0 + 2) break;
        end
        a_if.valid_i = 1'b0;
        chk("A second accept cycle", 16'(c), 16'd66);
        wait_a_idle();

        // Reset at cycle 20 of a frame: word lost, no done, then a fresh word right after release.
        a_if.data_i  = 16'h1234;
        a_if.valid_i = 1'b1;
        @(posedge clk); #1;
        a_if.valid_i = 1'b0;
        repeat (19) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("A async rst ser",   16'(a_if.ser_o),     16'd1);
        chk("A async rst frame", 16'(a_if.frame_o),   16'd0);
        chk("A async rst stb",   16'(a_if.bit_stb_o), 16'd0);
        chk("A async rst done",  16'(a_if.done_o),    16'd0);
        chk("A async rst ready", 16'(a_if.ready_o),   16'd1);
        chk("A async rst state", 16'(a_if.state),     16'(IDLE));
        @(posedge clk); #1;
        rst = 1'b0;
        a_if.data_i  = 16'h5A0F;
        a_if.valid_i = 1'b1;
        exp_q_a.push_back(16'h5A0F);
        @(posedge clk); #1;
        a_if.valid_i = 1'b0;
        chk("A accept after rst", 16'(mon_a.in_frame), 16'd1);
        wait_a_idle();

        // Narrow, undivided instance: 2'b10 then 2'b01.
        send_b(2'b10);
        wait_b_idle();
        send_b(2'b01);
        wait_b_idle();

        repeat (4) @(posedge clk);
        chk("A frames completed", 16'(mon_a.done_cnt), 16'd6);
        chk("B frames completed", 16'(mon_b.done_cnt), 16'd2);
        chk("A queue empty", 16'(exp_q_a.size()), 16'd0);
        chk("B queue empty", 16'(exp_q_b.size()), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
